// File: rtl/mips_defs.sv
// Shared MIPS definitions for the W stage: opcode and funct constants,
// the link register index and the write-back source selector.
package mips_defs;

    localparam logic [5:0] OP_RTYPE        = 6'h00;
    localparam logic [5:0] OP_ORI          = 6'h0d;
    localparam logic [5:0] OP_ADDIU        = 6'h09;
    localparam logic [5:0] OP_LUI          = 6'h0f;
    localparam logic [5:0] OP_LW           = 6'h23;
    localparam logic [5:0] OP_SW           = 6'h2b;
    localparam logic [5:0] OP_BEQ          = 6'h04;
    localparam logic [5:0] OP_JAL          = 6'h03;
    localparam logic [5:0] OP_BLEZ_BGEZALC = 6'h06;
    localparam logic [5:0] OP_LWSO         = 6'b110011;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_JR   = 6'h08;

    localparam logic [4:0] REG_RA = 5'd31;

    // Write-back data source
    typedef enum logic [1:0] {
        SEL_AO   = 2'd0,
        SEL_EXT  = 2'd1,
        SEL_RD   = 2'd2,
        SEL_LINK = 2'd3
    } wb_sel_e;

endpackage

// File: rtl/w_dst_decode.sv
// Destination / write-back source decode for the W stage.
// Ports:
//   instr        in   W-stage instruction
//   bgezalc_con  in   bgezalc link condition
//   lwso_con     in   lwso write condition
//   we           out  instruction writes a register (before the $0 filter)
//   dst          out  destination register index
//   sel          out  write-back data source
module w_dst_decode
    import mips_defs::*;
(
    input  logic [31:0] instr,
    input  logic        bgezalc_con,
    input  logic        lwso_con,
    output logic        we,
    output logic [4:0]  dst,
    output wb_sel_e     sel
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_shamt;

    assign op           = instr[31:26];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign funct        = instr[5:0];
    assign unused_shamt = ^instr[10:6];

    always_comb begin
        we  = 1'b0;
        dst = 5'd0;
        sel = SEL_AO;
        case (op)
            OP_RTYPE: begin
                if (funct == F_ADD || funct == F_ADDU ||
                    funct == F_SUB || funct == F_SUBU) begin
                    we  = 1'b1;
                    dst = rd;
                    sel = SEL_AO;
                end
            end
            OP_ORI, OP_ADDIU: begin
                we  = 1'b1;
                dst = rt;
                sel = SEL_AO;
            end
            OP_LUI: begin
                we  = 1'b1;
                dst = rt;
                sel = SEL_EXT;
            end
            OP_LW: begin
                we  = 1'b1;
                dst = rt;
                sel = SEL_RD;
            end
            OP_JAL: begin
                we  = 1'b1;
                dst = REG_RA;
                sel = SEL_LINK;
            end
            OP_BLEZ_BGEZALC: begin
                // Only the rs==rt, rt!=0 encoding is bgezalc; blez etc. never link
                if (rs == rt && rt != 5'd0 && bgezalc_con) begin
                    we  = 1'b1;
                    dst = REG_RA;
                    sel = SEL_LINK;
                end
            end
            OP_LWSO: begin
                if (lwso_con) begin
                    we  = 1'b1;
                    dst = rt;
                    sel = SEL_RD;
                end
            end
            default: begin
                we = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/w_stage_grf.sv
// W-stage register file: decodes the W instruction, commits its result into
// the 32x32 GRF, serves the two D-stage read ports with W-to-D bypass,
// exports the forwarding triple and counts retired (non-nop) instructions.
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   instr_w .. lwso_con_w W-stage pipeline fields
//   rs_addr, rt_addr      D-stage read addresses
//   rs_data, rt_data      bypassed read data
//   fwd_we/addr/data      W forwarding triple (addr/data zero when fwd_we=0)
//   retired               retired-instruction counter
// Optional: define GRF_TRACE_EN to print each committed write (simulation only).
module w_stage_grf
    import mips_defs::*;
#(
    parameter int RETIRE_W    = 32,
    parameter int LINK_OFFSET = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         instr_w,
    input  logic [31:0]         pc_w,
    input  logic [31:0]         ext32_w,
    input  logic [31:0]         ao_w,
    input  logic [31:0]         rd_w,
    input  logic                bgezalc_con_w,
    input  logic                lwso_con_w,
    input  logic [4:0]          rs_addr,
    input  logic [4:0]          rt_addr,
    output logic [31:0]         rs_data,
    output logic [31:0]         rt_data,
    output logic                fwd_we,
    output logic [4:0]          fwd_addr,
    output logic [31:0]         fwd_data,
    output logic [RETIRE_W-1:0] retired
);

    logic        dec_we;
    logic [4:0]  dec_dst;
    wb_sel_e     dec_sel;
    logic [31:0] wb_data;
    logic [31:0] grf [32];

    w_dst_decode u_dec (
        .instr       (instr_w),
        .bgezalc_con (bgezalc_con_w),
        .lwso_con    (lwso_con_w),
        .we          (dec_we),
        .dst         (dec_dst),
        .sel         (dec_sel)
    );

    always_comb begin
        wb_data = ao_w;
        case (dec_sel)
            SEL_AO:   wb_data = ao_w;
            SEL_EXT:  wb_data = ext32_w;
            SEL_RD:   wb_data = rd_w;
            SEL_LINK: wb_data = pc_w + 32'(LINK_OFFSET);
            default:  wb_data = ao_w;
        endcase
    end

    // Writes to $0 are filtered here so they neither commit nor forward
    assign fwd_we   = dec_we && (dec_dst != 5'd0);
    assign fwd_addr = fwd_we ? dec_dst : 5'd0;
    assign fwd_data = fwd_we ? wb_data : 32'd0;

    always_comb begin
        rs_data = 32'd0;
        if (rs_addr != 5'd0) begin
            rs_data = (fwd_we && rs_addr == fwd_addr) ? fwd_data : grf[rs_addr];
        end
    end

    always_comb begin
        rt_data = 32'd0;
        if (rt_addr != 5'd0) begin
            rt_data = (fwd_we && rt_addr == fwd_addr) ? fwd_data : grf[rt_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                grf[i] <= 32'd0;
            end
        end else if (fwd_we) begin
            grf[fwd_addr] <= fwd_data;
`ifdef GRF_TRACE_EN
            $display("@%h: $%d <= %h", pc_w, fwd_addr, fwd_data);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            retired <= '0;
        end else if (instr_w != 32'd0) begin
            retired <= retired + RETIRE_W'(1);
        end
    end

endmodule

// File: tb/tb_w_stage_grf.sv
module tb_w_stage_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_w, pc_w, ext32_w, ao_w, rd_w;
    logic        bgezalc_con_w, lwso_con_w;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic        fwd_we;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic [31:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    // reference state
    logic [31:0] ref_grf [32];
    logic [31:0] ref_ret;

    w_stage_grf #(.RETIRE_W(32), .LINK_OFFSET(8)) dut (
        .clk(clk), .reset(reset), .instr_w(instr_w), .pc_w(pc_w),
        .ext32_w(ext32_w), .ao_w(ao_w), .rd_w(rd_w),
        .bgezalc_con_w(bgezalc_con_w), .lwso_con_w(lwso_con_w),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data),
        .rt_data(rt_data), .fwd_we(fwd_we), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] f);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    // Expected write effect straight from the instruction-set rules
    task automatic model_write(output logic we, output logic [4:0] a, output logic [31:0] d);
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        logic [5:0] fn;
        op = instr_w[31:26]; rs = instr_w[25:21]; rt = instr_w[20:16];
        rd = instr_w[15:11]; fn = instr_w[5:0];
        we = 1'b0; a = 5'd0; d = 32'd0;
        if (op == 6'h00 && fn >= 6'h20 && fn <= 6'h23) begin we = 1; a = rd; d = ao_w; end
        else if (op == 6'h0d || op == 6'h09) begin we = 1; a = rt; d = ao_w; end
        else if (op == 6'h0f) begin we = 1; a = rt; d = ext32_w; end
        else if (op == 6'h23) begin we = 1; a = rt; d = rd_w; end
        else if (op == 6'h03) begin we = 1; a = 31; d = pc_w + 32'd8; end
        else if (op == 6'h06 && rs == rt && rt != 0 && bgezalc_con_w) begin we = 1; a = 31; d = pc_w + 32'd8; end
        else if (op == 6'h33 && lwso_con_w) begin we = 1; a = rt; d = rd_w; end
        if (a == 5'd0) we = 1'b0;
        if (!we) begin a = 5'd0; d = 32'd0; end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] ad, input logic we, input logic [4:0] a, input logic [31:0] d);
        if (ad == 5'd0) return 32'd0;
        if (we && ad == a) return d;
        return ref_grf[ad];
    endfunction

    // Check all outputs against the model, then clock and update the model.
    // Called 1 time unit after a rising edge.
    task automatic tick();
        logic we; logic [4:0] a; logic [31:0] d;
        #2;
        model_write(we, a, d);
        chk("fwd_we", 64'(fwd_we), 64'(we));
        chk("fwd_addr", 64'(fwd_addr), 64'(a));
        chk("fwd_data", 64'(fwd_data), 64'(d));
        chk("rs_data", 64'(rs_data), 64'(model_read(rs_addr, we, a, d)));
        chk("rt_data", 64'(rt_data), 64'(model_read(rt_addr, we, a, d)));
        chk("retired", 64'(retired), 64'(ref_ret));
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 32; i++) ref_grf[i] = 32'd0;
            ref_ret = 32'd0;
        end else begin
            if (we) ref_grf[a] = d;
            if (instr_w != 32'd0) ref_ret = ref_ret + 32'd1;
        end
        #1;
    endtask

    task automatic idle();
        instr_w = 32'd0; bgezalc_con_w = 0; lwso_con_w = 0;
    endtask

    task automatic rand_instr();
        int k;
        logic [5:0] fn;
        int r;
        k = $urandom_range(0, 12);
        r = $urandom_range(0, 31);
        case (k)
            0: begin
                fn = 6'(6'h20 + 6'($urandom_range(0, 3)));
                instr_w = enc_r($urandom_range(0, 31), $urandom_range(0, 31), r, fn);
            end
            1: instr_w = enc_i(6'h0d, $urandom_range(0, 31), r, 16'($urandom));
            2: instr_w = enc_i(6'h09, $urandom_range(0, 31), r, 16'($urandom));
            3: instr_w = enc_i(6'h0f, 0, r, 16'($urandom));
            4: instr_w = enc_i(6'h23, $urandom_range(0, 31), r, 16'($urandom));
            5: instr_w = {6'h03, 26'($urandom)};
            6: instr_w = enc_i(6'h06, r, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : r, 16'($urandom));
            7: instr_w = enc_i(6'h33, $urandom_range(0, 31), r, 16'($urandom));
            8: instr_w = enc_i(6'h2b, $urandom_range(0, 31), r, 16'($urandom));
            9: instr_w = enc_i(6'h04, $urandom_range(0, 31), r, 16'($urandom));
            10: instr_w = enc_r(r, 0, 0, 6'h08);
            11: instr_w = 32'd0;
            default: instr_w = $urandom;
        endcase
        pc_w = $urandom; ext32_w = $urandom; ao_w = $urandom; rd_w = $urandom;
        bgezalc_con_w = 1'($urandom); lwso_con_w = 1'($urandom);
        rs_addr = 5'($urandom); rt_addr = 5'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_grf[i] = 32'd0;
        ref_ret = 32'd0;
        reset = 0; idle();
        pc_w = 0; ext32_w = 0; ao_w = 0; rd_w = 0; rs_addr = 0; rt_addr = 0;
        @(posedge clk); #1;
        tick();
        reset = 1;

        // random writes, then reset clears everything
        for (int n = 0; n < 20; n++) begin rand_instr(); tick(); end
        reset = 0; rand_instr(); tick();
        reset = 1; idle();
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i); rt_addr = 5'(31 - i); #1;
            chk("rst_rs", 64'(rs_data), 64'd0);
            chk("rst_rt", 64'(rt_data), 64'd0);
        end
        chk("rst_ret", 64'(retired), 64'd0);

        // ori $8,$0,0x1234 with bypass during W
        instr_w = 32'h3408_1234; ao_w = 32'h0000_1234; rs_addr = 8; rt_addr = 0; #1;
        chk("ori_we", 64'(fwd_we), 64'd1);
        chk("ori_addr", 64'(fwd_addr), 64'd8);
        chk("ori_byp", 64'(rs_data), 64'h1234);
        tick();
        idle(); rt_addr = 8; #1;
        chk("ori_rd", 64'(rt_data), 64'h1234);

        // jal
        instr_w = 32'h0C00_0100; pc_w = 32'h0000_3000; tick();
        idle(); rs_addr = 31; #1;
        chk("jal", 64'(rs_data), 64'h3008);

        // bgezalc con=0 then con=1
        instr_w = enc_i(6'h06, 4, 4, 16'h0010); pc_w = 32'h3010; bgezalc_con_w = 0; #1;
        chk("bgz0_we", 64'(fwd_we), 64'd0);
        tick();
        idle(); rs_addr = 31; #1;
        chk("bgz0", 64'(rs_data), 64'h3008);
        instr_w = enc_i(6'h06, 4, 4, 16'h0010); pc_w = 32'h3010; bgezalc_con_w = 1; tick();
        idle(); #1;
        chk("bgz1", 64'(rs_data), 64'h3018);

        // lwso con=0 / con=1
        instr_w = enc_i(6'h33, 2, 5, 16'h0004); rd_w = 32'hDEAD_BEEF; lwso_con_w = 0; tick();
        idle(); rt_addr = 5; #1;
        chk("lwso0", 64'(rt_data), 64'd0);
        instr_w = enc_i(6'h33, 2, 5, 16'h0004); lwso_con_w = 1; tick();
        idle(); #1;
        chk("lwso1", 64'(rt_data), 64'hDEAD_BEEF);

        // add with rd=0
        instr_w = enc_r(3, 4, 0, 6'h20); ao_w = 32'h5555_AAAA; rs_addr = 0; #1;
        chk("r0_we", 64'(fwd_we), 64'd0);
        chk("r0_rd", 64'(rs_data), 64'd0);
        tick();
        idle(); #1;
        chk("r0_after", 64'(rs_data), 64'd0);

        // retired counter: 10 non-zero, 3 zero
        reset = 0; idle(); tick(); reset = 1;
        for (int n = 0; n < 13; n++) begin
            if (n == 2 || n == 6 || n == 11) idle();
            else instr_w = enc_i(6'h2b, 1, 2, 16'(n));
            tick();
        end
        idle(); #1;
        chk("ret10", 64'(retired), 64'd10);

        // reset during lw $9
        instr_w = enc_i(6'h23, 0, 9, 16'h0000); rd_w = 32'h1234_5678; reset = 0; tick();
        reset = 1; idle(); rt_addr = 9; #1;
        chk("lw_rst", 64'(rt_data), 64'd0);
        chk("lw_ret", 64'(retired), 64'd0);

        // randomized soak with occasional reset
        for (int n = 0; n < 400; n++) begin
            rand_instr();
            reset = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        reset = 1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/w_stage_grf.md
Name: w_stage_grf

Overview:
- Consumer end of the W pipeline register. Takes the W-stage fields (instr, pc, EXT32, AO, RD, bgezalc_con, lwso_con) and decodes the destination register and write-back source.
- Commits the result into the 32x32 general register file (GRF).
- Serves the D-stage read ports with W-to-D write-through bypass.
- Exports the W-stage forwarding triple to the hazard unit and keeps a retired-instruction counter.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter.
- LINK_OFFSET, 8, value added to pc for link writes (jal, bgezalc).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge).
- instr_w  in  32  W-stage instruction.
- pc_w  in  32  W-stage pc.
- ext32_w  in  32  W-stage extended immediate.
- ao_w  in  32  W-stage ALU result.
- rd_w  in  32  W-stage memory read data.
- bgezalc_con_w  in  1  bgezalc link condition.
- lwso_con_w  in  1  lwso write condition.
- rs_addr  in  5  D-stage read address A.
- rt_addr  in  5  D-stage read address B.
- rs_data  out  32  read data A, bypassed.
- rt_data  out  32  read data B, bypassed.
- fwd_we  out  1  W stage will write a non-zero register this cycle.
- fwd_addr  out  5  W destination; 0 when fwd_we=0.
- fwd_data  out  32  W write data; 0 when fwd_we=0.
- retired  out  RETIRE_W  count of committed non-nop instructions.

Behaviour:
- Decode is combinational on instr_w:
  - R-type add/addu/sub/subu (op 0, funct 0x20/0x21/0x22/0x23): dst=instr[15:11], data=ao_w.
  - ori 0x0d / addiu 0x09: dst=instr[20:16], data=ao_w.
  - lui 0x0f: dst=rt, data=ext32_w.
  - lw 0x23: dst=rt, data=rd_w.
  - jal 0x03: dst=31, data=pc_w+LINK_OFFSET (32-bit wrap).
  - bgezalc (op 0x06, rs==rt, rt!=0): dst=31, data=pc+8, only if bgezalc_con_w=1.
  - lwso (op OP_LWSO): dst=rt, data=rd_w, only if lwso_con_w=1.
  - All others (sw, beq, jr, nop, unknown): no write.
- fwd_we = decoded write && dst!=0. fwd_addr and fwd_data are forced to 0 when fwd_we=0.
- Write: on the clk edge with reset==1 and fwd_we==1, grf[fwd_addr] <= fwd_data. Write latency is 1 cycle; the value is visible in the array on the next cycle.
- $0 always reads 0. Writes to it are dropped and are not traced.
- Read is combinational:
  - rs_data = (rs_addr!=0 && fwd_we && rs_addr==fwd_addr) ? fwd_data : grf[rs_addr].
  - rt_data follows the same rule on rt_addr.
- Simultaneous read and write of the same register in one cycle returns the new data through the bypass.
- retired increments by 1 on each non-reset edge where instr_w!=0, regardless of whether a write occurs. It wraps at 2^RETIRE_W.
- Reset (reset==0 at an edge): all 32 registers <= 0 and retired <= 0 in that single cycle. No write is performed at that edge, even if fwd_we=1.
- Reset mid-stream discards the pending W write.
- Outputs during reset are combinational on the inputs; their post-reset values are rs/rt_data=0 for any address with no W write pending.

Optional Feature:
- GRF_TRACE_EN:
  - Defined: on every committed write, $display("@%h: $%d <= %h", pc_w, fwd_addr, fwd_data) at that clk edge. Simulation only, so synthesis is unaffected.
  - Undefined: no display code is compiled.

Decomposition:
- Shared package (mips_defs): opcode constants OP_RTYPE, OP_ORI, OP_ADDIU, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_BLEZ_BGEZALC, OP_LWSO (6'b110011); funct constants F_ADD, F_ADDU, F_SUB, F_SUBU, F_JR; register index REG_RA=31.
- One natural sub-module, w_dst_decode: combinational instr/con inputs -> {we, dst, sel}. The top module holds the array, bypass mux and counter.

Test Plan:
- Reset: hold reset=0 for 1 edge after random writes -> every rs_addr/rt_addr reads 0, retired=0.
- ori: instr=0x3408_1234 (ori $8,$0,0x1234), ao_w=0x1234, then nop -> next cycle rt_addr=8 gives 0x00001234. During the W cycle, fwd_we=1, fwd_addr=8, and rs_addr=8 is bypassed to 0x1234.
- jal: pc_w=0x0000_3000 -> $31=0x0000_3008.
- bgezalc: pc_w=0x3010 with con=0 -> $31 unchanged and fwd_we=0; same with con=1 -> $31=0x3018.
- lwso and $0:
  - lwso with rt=5, rd_w=0xDEADBEEF: con=0 -> no write; con=1 -> $5=0xDEADBEEF.
  - R-type add with rd=0 -> fwd_we=0 and $0 reads 0.
- Counter: 10 non-zero instrs interleaved with 3 zero instrs -> retired=10. Assert reset=0 mid-sequence during lw $9 -> $9 stays 0 and retired=0.
